mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised iterative multiply/divide unit for the MIPS datapath. It adds MULT, MULTU, DIV and DIVU with architectural HI/LO registers, which the current single-cycle ALU cannot provide. It sits beside the ALU and is fed from Register_File read data. It runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles and reports progress through a busy/done handshake, so the controller can stall on MFHI/MFLO.

## Interface
- WIDTH, 32: operand, HI and LO width in bits; legal range 4 to 64.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  request a new operation; accepted only when busy=0.
- op  in  2  operation select, captured with start:
  - 0 = MULTU
  - 1 = MULT
  - 2 = DIVU
  - 3 = DIV
- operand_a  in  WIDTH  multiplicand or dividend (rs).
- operand_b  in  WIDTH  multiplier or divisor (rt).
- mthi  in  1  write operand_a into hi (MTHI).
- mtlo  in  1  write operand_a into lo (MTLO).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi and lo hold the new result.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.
- div_by_zero  out  1  last completed operation was a division with operand_b=0.

## Operation
- **States:** IDLE, CALC, FIXUP.
  - IDLE: start=1 captures op and operands, then moves to CALC.
  - CALC: after WIDTH iterations, moves to FIXUP.
  - FIXUP: always returns to IDLE.
- **Capture:** operands are converted to magnitudes when op is signed (MULT, DIV). The result sign and remainder sign are recorded at capture.
- **Multiply:** one shift-add step per CALC cycle on a 2*WIDTH accumulator. In FIXUP, the product is negated if exactly one operand was negative. The result is {hi,lo} as a 2*WIDTH two's-complement or unsigned product.
- **Divide:** one restoring step per CALC cycle; each step produces a quotient bit. In FIXUP:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of operand_a;
  - lo = quotient, hi = remainder.
- **Divide by zero** (operand_b=0 at capture): the full latency is still taken. Result is lo = all ones, hi = operand_a as captured, div_by_zero=1.
- **Signed overflow** (DIV of most-negative by -1): lo = most-negative, hi = 0, div_by_zero=0.
- **div_by_zero update:** written at each completion; multiplies clear it.
- **mthi/mtlo:** take effect on the edge only when busy=0. They are ignored while busy=1. If asserted together with an accepted start, the write happens and is later overwritten at completion.
- **Ignored inputs:** start while busy=1 is ignored; the operation in flight is unaffected. Operands and op are not required to stay stable after the accept edge.

## Timing
- **Reset:** state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset mid-operation aborts immediately and discards the partial result.
- **Accept edge E:** start=1 with busy=0 is sampled at edge E. busy=1 from edge E.
- **Iterations:** edges E+1 through E+WIDTH perform the iterations.
- **Completion edge E+WIDTH+1 (FIXUP):**
  - hi, lo and div_by_zero are written;
  - done=1 for exactly one cycle;
  - busy=0.
- **Latency:** WIDTH+1 cycles from accept to done; busy is high for WIDTH+1 cycles.
- **Back-to-back:** start may be asserted in the done cycle and is accepted at that edge, giving a zero-bubble back-to-back issue.
- **Register timing:** hi and lo are registered outputs. They hold the previous values throughout busy and never show intermediate values.

## Test plan
1. Reset, then MULTU with 0xFFFFFFFF, 0xFFFFFFFF -> done exactly 33 cycles after the accept edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
2. MULT with -3, 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then issue MULT 0x80000000 × 0x80000000 in the done cycle -> hi=0x40000000, lo=0x00000000, with no idle cycle between the two operations.
3. Two divides:
   - DIVU 100/7 -> lo=14, hi=2;
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_by_zero=0 for both.
4. Division corner cases:
   - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1, latency 33;
   - then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
5. Protocol checks:
   - start with different operands and mthi=1 asserted 5 cycles after accept -> both ignored; result matches the first operation;
   - reset asserted 10 cycles into an operation -> next cycle busy=0, hi=lo=0, and no done pulse.
6. WIDTH=8 instance:
   - MULT 0x80×0x80 -> hi=0x40, lo=0x00, latency 9;
   - DIV 0xF9/0x02 -> lo=0xFD, hi=0xFF;
   - mtlo with operand_a=0x5A while idle -> lo=0x5A next cycle.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// Signed operands are reduced to magnitudes at capture and the signs are restored in FIXUP.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    a_neg     = op[0] & operand_a[WIDTH-1];
    b_neg     = op[0] & operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    // Divide: shift next dividend bit into the remainder and try subtracting the divisor.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_diff  = div_shift[WIDTH-1:0] - mcand_q;
    prod      = {acc_hi_q, acc_lo_q};
    prod_neg  = -prod;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mthi) hi_d = operand_a;
        if (mtlo) lo_d = operand_a;
        if (start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_zero_d  = (operand_b == '0);
          acc_hi_d  = '0;
          acc_lo_d  = op[1] ? a_mag : b_mag;
          mcand_d   = op[1] ? b_mag : a_mag;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFixup;
      end
      StFixup: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          // With a zero divisor the remainder path already reconstructs operand_a.
          lo_d  = b_zero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
          hi_d  = neg_rem_q ? -acc_hi_q : acc_hi_q;
          dbz_d = b_zero_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
          dbz_d        = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: a 32-bit and an 8-bit instance share one clock.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;

  logic        start32, mthi32, mtlo32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;

  logic        start8, mthi8, mtlo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;
  int lat, bcyc, edges, pulses;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clock       (clock),
    .reset       (reset),
    .start       (start32),
    .op          (op32),
    .operand_a   (a32),
    .operand_b   (b32),
    .mthi        (mthi32),
    .mtlo        (mtlo32),
    .busy        (busy32),
    .done        (done32),
    .hi          (hi32),
    .lo          (lo32),
    .div_by_zero (dbz32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clock       (clock),
    .reset       (reset),
    .start       (start8),
    .op          (op8),
    .operand_a   (a8),
    .operand_b   (b8),
    .mthi        (mthi8),
    .mtlo        (mtlo8),
    .busy        (busy8),
    .done        (done8),
    .hi          (hi8),
    .lo          (lo8),
    .div_by_zero (dbz8)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dut_busy(input bit s8);
    return s8 ? busy8 : busy32;
  endfunction

  function automatic logic dut_done(input bit s8);
    return s8 ? done8 : done32;
  endfunction

  // Drives a request now; the next rising edge accepts it.
  task automatic issue(input bit s8, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    if (s8) begin
      op8 = o; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      op32 = o; a32 = a; b32 = b; start32 = 1'b1;
    end
  endtask

  // Returns #1 after the edge at which done rose; lat counts edges after the accept edge.
  task automatic wait_done(input bit s8, output int l, output int bc);
    @(posedge clock); #1;
    start32 = 1'b0;
    start8  = 1'b0;
    l  = 0;
    bc = dut_busy(s8) ? 1 : 0;
    while (!dut_done(s8) && l < 200) begin
      @(posedge clock); #1;
      l++;
      if (dut_busy(s8)) bc++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; mthi8  = 1'b0; mtlo8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", busy32, 0);
    check_eq("rst_done", done32, 0);
    check_eq("rst_hi", hi32, 0);
    check_eq("rst_lo", lo32, 0);
    check_eq("rst_dbz", dbz32, 0);
    @(negedge clock);
    reset = 1'b0;

    // MULTU all-ones squared
    @(negedge clock);
    issue(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat, bcyc);
    check_eq("multu_lat", lat, 33);
    check_eq("multu_busy_cycles", bcyc, 33);
    check_eq("multu_hi", hi32, 32'hFFFF_FFFE);
    check_eq("multu_lo", lo32, 32'h0000_0001);
    check_eq("multu_dbz", dbz32, 0);
    @(posedge clock); #1;
    check_eq("done_one_cycle", done32, 0);

    // MULT -3*7, then back-to-back MULT issued in the done cycle
    @(negedge clock);
    issue(0, 2'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, lat, bcyc);
    check_eq("mult_neg_hi", hi32, 32'hFFFF_FFFF);
    check_eq("mult_neg_lo", lo32, 32'hFFFF_FFEB);
    check_eq("done_cycle_busy", busy32, 0);
    issue(0, 2'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, lat, bcyc);
    check_eq("b2b_lat", lat, 33);
    check_eq("b2b_busy_cycles", bcyc, 33);
    check_eq("mult_min_hi", hi32, 32'h4000_0000);
    check_eq("mult_min_lo", lo32, 32'h0000_0000);

    // Divides
    @(negedge clock);
    issue(0, 2'd2, 32'd100, 32'd7);
    wait_done(0, lat, bcyc);
    check_eq("divu_lo", lo32, 32'd14);
    check_eq("divu_hi", hi32, 32'd2);
    check_eq("divu_dbz", dbz32, 0);
    @(negedge clock);
    issue(0, 2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, lat, bcyc);
    check_eq("div_neg_lo", lo32, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hi32, 32'hFFFF_FFFF);
    check_eq("div_neg_dbz", dbz32, 0);

    // Division corner cases
    @(negedge clock);
    issue(0, 2'd2, 32'd5, 32'd0);
    wait_done(0, lat, bcyc);
    check_eq("dbz_lat", lat, 33);
    check_eq("dbz_lo", lo32, 32'hFFFF_FFFF);
    check_eq("dbz_hi", hi32, 32'd5);
    check_eq("dbz_flag", dbz32, 1);
    @(negedge clock);
    issue(0, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat, bcyc);
    check_eq("ovf_lo", lo32, 32'h8000_0000);
    check_eq("ovf_hi", hi32, 32'h0);
    check_eq("ovf_dbz", dbz32, 0);

    // start and mthi while busy are ignored; hi/lo hold during the operation
    @(negedge clock);
    issue(0, 2'd0, 32'd6, 32'd7);
    @(posedge clock); #1;
    start32 = 1'b0;
    edges = 0;
    repeat (4) begin @(posedge clock); #1; edges++; end
    issue(0, 2'd2, 32'd99, 32'd3);
    mthi32 = 1'b1;
    @(posedge clock); #1;
    edges++;
    start32 = 1'b0;
    mthi32  = 1'b0;
    check_eq("busy_mthi_ignored", hi32, 32'h0);
    check_eq("busy_lo_holds", lo32, 32'h8000_0000);
    while (!done32 && edges < 200) begin @(posedge clock); #1; edges++; end
    check_eq("ignore_lat", edges, 33);
    check_eq("ignore_lo", lo32, 32'd42);
    check_eq("ignore_hi", hi32, 32'd0);

    // Reset mid-operation aborts with no done pulse
    @(negedge clock);
    issue(0, 2'd0, 32'd3, 32'd5);
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("abort_busy", busy32, 0);
    check_eq("abort_hi", hi32, 0);
    check_eq("abort_lo", lo32, 0);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin @(posedge clock); #1; if (done32) pulses++; end
    check_eq("abort_no_done", pulses, 0);

    // WIDTH=8 instance
    @(negedge clock);
    issue(1, 2'd1, 32'h80, 32'h80);
    wait_done(1, lat, bcyc);
    check_eq("w8_mult_lat", lat, 9);
    check_eq("w8_mult_hi", hi8, 8'h40);
    check_eq("w8_mult_lo", lo8, 8'h00);
    @(negedge clock);
    issue(1, 2'd3, 32'hF9, 32'h02);
    wait_done(1, lat, bcyc);
    check_eq("w8_div_lo", lo8, 8'hFD);
    check_eq("w8_div_hi", hi8, 8'hFF);
    @(negedge clock);
    a8    = 8'h5A;
    mtlo8 = 1'b1;
    @(posedge clock); #1;
    mtlo8 = 1'b0;
    check_eq("w8_mtlo", lo8, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
